// File: rtl/shift_saturate.sv
// Narrowing stage after the barrel shifter: saturates the wide signed result,
// buffers it in a two-entry skid buffer and counts saturation events.
module shift_saturate #(
    parameter int data_width_in  = 18,
    parameter int data_width_out = 8,
    parameter int count_width    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic signed [data_width_in-1:0]  dataIn,
    output logic                             outValid,
    input  logic                             outReady,
    output logic signed [data_width_out-1:0] dataOut,
    output logic                             satFlag,
    input  logic                             clearCount,
    output logic [count_width-1:0]           satCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic signed [data_width_in-1:0] MaxVal =
        {{(data_width_in-data_width_out+1){1'b0}}, {(data_width_out-1){1'b1}}};
    localparam logic signed [data_width_in-1:0] MinVal =
        {{(data_width_in-data_width_out+1){1'b1}}, {(data_width_out-1){1'b0}}};
    localparam logic [count_width-1:0] CountOne = {{(count_width-1){1'b0}}, 1'b1};

    state_t                            state_q, state_d;
    logic signed [data_width_out-1:0]  mainData_q, skidData_q;
    logic                              mainFlag_q, skidFlag_q;
    logic [count_width-1:0]            count_q, count_d;

    logic signed [data_width_out-1:0]  satData;
    logic                              satHit;
    logic                              accept, pop;
    logic                              loadMain, loadSkid, skidToMain;

    // Clip on the full-width signed value; boundary values pass unflagged.
    always_comb begin
        satData = dataIn[data_width_out-1:0];
        satHit  = 1'b0;
        if (dataIn > MaxVal) begin
            satData = MaxVal[data_width_out-1:0];
            satHit  = 1'b1;
        end else if (dataIn < MinVal) begin
            satData = MinVal[data_width_out-1:0];
            satHit  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        loadMain   = 1'b0;
        loadSkid   = 1'b0;
        skidToMain = 1'b0;
        inReady    = (state_q != TWO);
        outValid   = (state_q != EMPTY);
        accept     = inValid & inReady;
        pop        = outValid & outReady;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    loadMain = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    loadMain = 1'b1;
                end else if (accept) begin
                    loadSkid = 1'b1;
                    state_d  = TWO;
                end else if (pop) begin
                    state_d  = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    skidToMain = 1'b1;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Clear beats increment; the counter parks at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clearCount) begin
            count_d = '0;
        end else if (accept && satHit && !(&count_q)) begin
            count_d = count_q + CountOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainFlag_q <= 1'b0;
            skidData_q <= '0;
            skidFlag_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (loadMain) begin
                mainData_q <= satData;
                mainFlag_q <= satHit;
            end else if (skidToMain) begin
                mainData_q <= skidData_q;
                mainFlag_q <= skidFlag_q;
            end
            if (loadSkid) begin
                skidData_q <= satData;
                skidFlag_q <= satHit;
            end
        end
    end

    assign dataOut  = mainData_q;
    assign satFlag  = mainFlag_q;
    assign satCount = count_q;

endmodule

// File: tb/tb_shift_saturate.sv
// Self-checking bench for shift_saturate: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_shift_saturate;

    localparam int InW    = 18;
    localparam int OutW   = 8;
    localparam int CntW   = 16;
    localparam int OutMax = 127;
    localparam int OutMin = -128;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   inValid = 1'b0;
    logic                   outReady = 1'b0;
    logic                   clearCount = 1'b0;
    logic signed [InW-1:0]  dataIn = '0;

    logic                   inReady, outValid, satFlag;
    logic signed [OutW-1:0] dataOut;
    logic [CntW-1:0]        satCount;

    logic                   inReady2, outValid2, satFlag2;
    logic signed [OutW-1:0] dataOut2;
    logic [1:0]             satCount2;

    shift_saturate #(.data_width_in(InW), .data_width_out(OutW), .count_width(CntW)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .dataIn(dataIn),
        .outValid(outValid), .outReady(outReady), .dataOut(dataOut), .satFlag(satFlag),
        .clearCount(clearCount), .satCount(satCount)
    );

    shift_saturate #(.data_width_in(InW), .data_width_out(OutW), .count_width(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady2), .dataIn(dataIn),
        .outValid(outValid2), .outReady(outReady), .dataOut(dataOut2), .satFlag(satFlag2),
        .clearCount(clearCount), .satCount(satCount2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int qData[$];
    bit qFlag[$];
    int modelCnt = 0;
    int modelCnt2 = 0;
    int acceptCount = 0;
    bit capAccept = 1'b0;
    bit capPop = 1'b0;
    bit capClear = 1'b0;
    int capVal = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int satValue(input int v);
        if (v > OutMax) return OutMax;
        if (v < OutMin) return OutMin;
        return v;
    endfunction

    function automatic bit satHit(input int v);
        return (v > OutMax) || (v < OutMin);
    endfunction

    // Compare DUT against the model mid-cycle, and capture this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rstOutValid", int'(outValid), 0);
            checkOutput("rstInReady", int'(inReady), 1);
            checkOutput("rstDataOut", int'(dataOut), 0);
            checkOutput("rstSatFlag", int'(satFlag), 0);
            checkOutput("rstSatCount", int'(satCount), 0);
            checkOutput("rstSatCount2", int'(satCount2), 0);
            qData.delete();
            qFlag.delete();
            modelCnt  = 0;
            modelCnt2 = 0;
            capAccept = 1'b0;
            capPop    = 1'b0;
            capClear  = 1'b0;
        end else begin
            checkOutput("outValid", int'(outValid), int'(qData.size() > 0));
            checkOutput("inReady", int'(inReady), int'(qData.size() < 2));
            checkOutput("satCount", int'(satCount), modelCnt);
            checkOutput("satCount2", int'(satCount2), modelCnt2);
            if (qData.size() > 0) begin
                checkOutput("dataOut", int'(dataOut), qData[0]);
                checkOutput("satFlag", int'(satFlag), int'(qFlag[0]));
            end
            capAccept = inValid && (qData.size() < 2);
            capPop    = (qData.size() > 0) && outReady;
            capClear  = clearCount;
            capVal    = int'(dataIn);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (capPop) begin
                void'(qData.pop_front());
                void'(qFlag.pop_front());
            end
            if (capAccept) begin
                qData.push_back(satValue(capVal));
                qFlag.push_back(satHit(capVal));
                acceptCount++;
            end
            if (capClear) begin
                modelCnt  = 0;
                modelCnt2 = 0;
            end else if (capAccept && satHit(capVal)) begin
                if (modelCnt < 65535) modelCnt++;
                if (modelCnt2 < 3) modelCnt2++;
            end
        end
    end

    task automatic applyStimulus(input bit valid, input int value, input bit ready, input bit clear);
        inValid    = valid;
        dataIn     = InW'(value);
        outReady   = ready;
        clearCount = clear;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int satIn[7]   = '{5, 300, -300, 127, -128, 128, -129};
    int satOut[7]  = '{5, 127, -128, 127, -128, 127, -128};
    int satFlg[7]  = '{0, 1, 1, 0, 0, 1, 1};

    initial begin
        // Reset held with a valid input offered.
        applyStimulus(1'b1, 7, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutValid", int'(outValid), 0);
        checkOutput("resetInReady", int'(inReady), 1);
        checkOutput("resetDataOut", int'(dataOut), 0);
        checkOutput("resetSatCount", int'(satCount), 0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("firstOutValid", int'(outValid), 1);
        checkOutput("firstDataOut", int'(dataOut), 7);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("drainOutValid", int'(outValid), 0);

        // Saturation boundaries at full throughput.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, satIn[i], 1'b1, 1'b0);
            nextCycle();
            checkOutput("satVecData", int'(dataOut), satOut[i]);
            checkOutput("satVecFlag", int'(satFlag), satFlg[i]);
        end
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("satVecCount", int'(satCount), 4);
        nextCycle();

        // Backpressure fills both entries, third item must wait.
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 2, 1'b0, 1'b0);
        nextCycle();
        checkOutput("bpFullReady", int'(inReady), 0);
        checkOutput("bpHoldData", int'(dataOut), 1);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        nextCycle();
        checkOutput("bpStillFull", int'(inReady), 0);
        checkOutput("bpStillData", int'(dataOut), 1);
        applyStimulus(1'b1, 3, 1'b1, 1'b0);
        nextCycle();
        checkOutput("bpSecondData", int'(dataOut), 2);
        checkOutput("bpReadyAgain", int'(inReady), 1);
        nextCycle();
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("bpThirdData", int'(dataOut), 3);
        nextCycle();
        checkOutput("bpEmpty", int'(outValid), 0);

        // Counter increment, clear priority and saturation of the 2-bit counter.
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 300, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("cnt3", int'(satCount), 3);
        checkOutput("cnt3Small", int'(satCount2), 3);
        applyStimulus(1'b1, -300, 1'b1, 1'b1);
        nextCycle();
        checkOutput("cntClearWins", int'(satCount), 0);
        checkOutput("cntClearWinsSmall", int'(satCount2), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 500, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("cnt5", int'(satCount), 5);
        checkOutput("cntStickSmall", int'(satCount2), 3);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        nextCycle();

        // Random streaming against the model.
        acceptCount = 0;
        for (int cyc = 0; cyc < 20000 && acceptCount < 1000; cyc++) begin
            int v;
            if ($urandom_range(0, 3) == 0) v = int'($signed(InW'($urandom)));
            else v = int'($urandom_range(0, 800)) - 400;
            applyStimulus(bit'($urandom_range(0, 1)), v, bit'($urandom_range(0, 1)), 1'b0);
            nextCycle();
        end
        checkOutput("streamAccepted", acceptCount, 1000);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        repeat (3) nextCycle();
        checkOutput("streamDrained", int'(outValid), 0);

        // Asynchronous reset while two items are buffered.
        applyStimulus(1'b1, 11, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 12, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("preRstFull", int'(inReady), 0);
        checkOutput("preRstValid", int'(outValid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncOutValid", int'(outValid), 0);
        checkOutput("asyncInReady", int'(inReady), 1);
        checkOutput("asyncDataOut", int'(dataOut), 0);
        checkOutput("asyncSatFlag", int'(satFlag), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("postRstNoEmit", int'(outValid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
